// File: rtl/swap_cmd_sequencer_pkg.sv
// Shared definitions for the swap command sequencer: FSM state encoding
// and the reserved scratch register address.
package swap_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } seq_state_t;

  localparam int unsigned SCRATCH_ADDR = 0;

endpackage

// File: rtl/swap_cmd_sequencer_fifo.sv
// Small synchronous FIFO with occupancy count, used to buffer swap requests.
// No bypass: a pushed entry becomes visible at the head one cycle later.
module sync_fifo_nbit #(
  parameter int n     = 14,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [n-1:0]             push_data,
  input  logic                     pop,
  output logic [n-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int pw = $clog2(depth);
  localparam logic [pw:0] full_count = depth[pw:0];

  logic [n-1:0]  mem [depth];
  logic [pw-1:0] wr_ptr;
  logic [pw-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == full_count);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/swap_cmd_sequencer.sv
// Buffers swap requests, issues them as one-cycle swap pulses with stable
// operand addresses, and stalls host writes while a swap owns the register file.
module swap_cmd_sequencer
  import swap_cmd_sequencer_pkg::*;
#(
  parameter int address_width = 7,
  parameter int data_width    = 8,
  parameter int depth         = 4,
  parameter int swap_cycles   = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [address_width-1:0]  req_addr_a,
  input  logic [address_width-1:0]  req_addr_b,
  input  logic                      host_we,
  input  logic [address_width-1:0]  host_address_w,
  input  logic [data_width-1:0]     host_data_w,
  output logic                      host_stall,
  output logic [address_width-1:0]  address_a,
  output logic [address_width-1:0]  address_b,
  output logic                      swap,
  output logic                      we,
  output logic [address_width-1:0]  address_w,
  output logic [data_width-1:0]     data_w,
  output logic                      busy,
  output logic                      done,
  output logic                      err_zero_addr,
  output logic [$clog2(depth):0]    pending
);

  localparam int cw = $clog2(swap_cycles + 2);
  localparam logic [address_width-1:0] scratch = address_width'(SCRATCH_ADDR);

  seq_state_t                  state;
  logic [cw-1:0]               cnt;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic                        fifo_push;
  logic                        accept;
  logic                        zero_req;
  logic [2*address_width-1:0]  head;

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign zero_req  = (req_addr_a == scratch) || (req_addr_b == scratch);
  assign fifo_push = accept && !zero_req;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  assign host_stall = busy || ((state == IDLE) && !fifo_empty);
  assign we         = host_we && !host_stall;
  assign address_w  = host_address_w;
  assign data_w     = host_data_w;

  sync_fifo_nbit #(
    .n     (2*address_width),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({req_addr_a, req_addr_b}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // done is registered, so it is raised one step ahead of the counter hitting 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      swap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      address_a <= '0;
      address_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state                  <= ISSUE;
            {address_a, address_b} <= head;
            swap                   <= 1'b1;
            busy                   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= BUSY;
          swap  <= 1'b0;
          cnt   <= cw'(swap_cycles);
          done  <= (swap_cycles == 1);
        end
        BUSY: begin
          if (cnt == cw'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == cw'(2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_zero_addr <= 1'b0;
    else          err_zero_addr <= accept && zero_req;
  end

endmodule

// File: tb/tb_swap_cmd_sequencer.sv
// Self-checking bench: a queue/time-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_swap_cmd_sequencer;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SC    = 3;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr_a = '0;
  logic [AW-1:0] req_addr_b = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_address_w = '0;
  logic [DW-1:0] host_data_w = '0;
  logic          host_stall;
  logic [AW-1:0] address_a;
  logic [AW-1:0] address_b;
  logic          swap;
  logic          we;
  logic [AW-1:0] address_w;
  logic [DW-1:0] data_w;
  logic          busy;
  logic          done;
  logic          err_zero_addr;
  logic [PW-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  swap_cmd_sequencer #(
    .address_width (AW),
    .data_width    (DW),
    .depth         (DEPTH),
    .swap_cycles   (SC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr_a     (req_addr_a),
    .req_addr_b     (req_addr_b),
    .host_we        (host_we),
    .host_address_w (host_address_w),
    .host_data_w    (host_data_w),
    .host_stall     (host_stall),
    .address_a      (address_a),
    .address_b      (address_b),
    .swap           (swap),
    .we             (we),
    .address_w      (address_w),
    .data_w         (data_w),
    .busy           (busy),
    .done           (done),
    .err_zero_addr  (err_zero_addr),
    .pending        (pending)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic hwe, input logic [AW-1:0] hw, input logic [DW-1:0] hd);
    @(posedge clk);
    #1;
    req_valid      = v;
    req_addr_a     = a;
    req_addr_b     = b;
    host_we        = hwe;
    host_address_w = hw;
    host_data_w    = hd;
  endtask

  // Reference model: stored requests as a queue, swap timing as the cycle of the last pulse.
  logic [2*AW-1:0] mq[$];
  int              cyc    = 0;
  int              s_last = -1000;
  logic [AW-1:0]   m_a    = '0;
  logic [AW-1:0]   m_b    = '0;
  logic            m_err  = 1'b0;

  always @(negedge clk) begin
    int   age;
    logic m_busy;
    logic m_stall;
    logic m_fire;
    logic m_zero;
    logic [2*AW-1:0] head;
    if (!reset_n) begin
      mq.delete();
      s_last = -1000;
      m_a    = '0;
      m_b    = '0;
      m_err  = 1'b0;
    end
    age     = cyc - s_last;
    m_busy  = (age >= 0) && (age <= SC);
    m_stall = m_busy || (mq.size() > 0);
    checkOutput("m_swap",      swap,          (age == 0));
    checkOutput("m_busy",      busy,          m_busy);
    checkOutput("m_done",      done,          (age == SC));
    checkOutput("m_err",       err_zero_addr, m_err);
    checkOutput("m_pending",   pending,       mq.size());
    checkOutput("m_ready",     req_ready,     (mq.size() < DEPTH));
    checkOutput("m_stall",     host_stall,    m_stall);
    checkOutput("m_we",        we,            host_we && !m_stall);
    checkOutput("m_addr_a",    address_a,     m_a);
    checkOutput("m_addr_b",    address_b,     m_b);
    checkOutput("m_address_w", address_w,     host_address_w);
    checkOutput("m_data_w",    data_w,        host_data_w);
    if (reset_n) begin
      m_fire = req_valid && (mq.size() < DEPTH);
      m_zero = m_fire && ((req_addr_a == 0) || (req_addr_b == 0));
      if (!m_busy && mq.size() > 0) begin
        head   = mq.pop_front();
        m_a    = head[2*AW-1:AW];
        m_b    = head[AW-1:0];
        s_last = cyc + 1;
      end
      if (m_fire && !m_zero) mq.push_back({req_addr_a, req_addr_b});
      m_err = m_zero;
    end
    cyc++;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single swap with a host write held on address 7 from the following cycle.
    applyStimulus(1, 5, 9, 0, 0, 0);
    @(negedge clk);
    checkOutput("c0_ready", req_ready, 1);
    checkOutput("c0_pending", pending, 0);
    applyStimulus(0, 0, 0, 1, 7, 8'h5a);
    @(negedge clk);
    checkOutput("c1_pending", pending, 1);
    checkOutput("c1_stall", host_stall, 1);
    checkOutput("c1_swap", swap, 0);
    applyStimulus(0, 0, 0, 1, 7, 8'h5a);
    @(negedge clk);
    checkOutput("c2_swap", swap, 1);
    checkOutput("c2_addr_a", address_a, 5);
    checkOutput("c2_addr_b", address_b, 9);
    checkOutput("c2_busy", busy, 1);
    checkOutput("c2_we", we, 0);
    repeat (2) begin
      applyStimulus(0, 0, 0, 1, 7, 8'h5a);
      @(negedge clk);
      checkOutput("c34_done", done, 0);
      checkOutput("c34_stall", host_stall, 1);
    end
    applyStimulus(0, 0, 0, 1, 7, 8'h5a);
    @(negedge clk);
    checkOutput("c5_done", done, 1);
    checkOutput("c5_busy", busy, 1);
    applyStimulus(0, 0, 0, 1, 7, 8'h5a);
    @(negedge clk);
    checkOutput("c6_busy", busy, 0);
    checkOutput("c6_stall", host_stall, 0);
    checkOutput("c6_we", we, 1);
    checkOutput("c6_addr_w", address_w, 7);
    checkOutput("c6_addr_a_held", address_a, 5);

    // Request naming the scratch register is consumed but dropped.
    applyStimulus(1, 0, 3, 0, 0, 0);
    @(negedge clk);
    checkOutput("z0_err", err_zero_addr, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("z1_err", err_zero_addr, 1);
    checkOutput("z1_pending", pending, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("z2_swap", swap, 0);
    checkOutput("z2_err", err_zero_addr, 0);

    // Fill the FIFO while the first entry is in flight.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, AW'(10 + i), AW'(20 + i), 0, 0, 0);
      @(negedge clk);
      if (i == 2) checkOutput("f2_swap", swap, 1);
      if (i == 5) begin
        checkOutput("f5_ready", req_ready, 0);
        checkOutput("f5_pending", pending, 4);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("f6_swap", swap, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("f7_swap", swap, 1);
    checkOutput("f7_addr_a", address_a, 11);
    checkOutput("f7_addr_b", address_b, 21);
    repeat (25) applyStimulus(0, 0, 0, 0, 0, 0);

    // Same-cycle conflict followed by a reset two cycles into the swap.
    applyStimulus(1, 3, 4, 0, 0, 0);
    applyStimulus(1, 6, 7, 1, 2, 8'h11);
    @(negedge clk);
    checkOutput("r1_stall", host_stall, 1);
    checkOutput("r1_we", we, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r2_swap", swap, 1);
    checkOutput("r2_addr_a", address_a, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("r4_busy", busy, 0);
    checkOutput("r4_swap", swap, 0);
    checkOutput("r4_pending", pending, 0);
    checkOutput("r4_addr_a", address_a, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (8) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("r_swap_quiet", swap, 0);
      checkOutput("r_done_quiet", done, 0);
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 99) < 60,
                    AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      reset_n = ($urandom_range(0, 149) != 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
